// File: rtl/gate_updown_counter_if.sv
// Handshake bundle for gate_updown_counter: control/load inputs plus
// the registered count, combinational terminal count and wrap pulse.
interface gate_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic             dir;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (output en, load, dir, din, input count, tc, wrap);
    modport slave  (input en, load, dir, din, output count, tc, wrap);
endinterface

// File: rtl/gate_updown_counter.sv
// gate_updown_counter: loadable up/down counter whose next-state path is
// built only from nand_gate / not_gate / and_gate cells, with one D flop
// per state bit. Ripple-carry incrementer/decrementer, NAND-built XOR and
// NAND-built load mux per bit.
// Optional build macro GATE_COUNTER_SATURATE_EN: saturate at all-ones/zero
// instead of wrapping; wrap then never asserts.
// The first clock edge after reset release is ignored (r_arm), so an edge
// that coincides with rst_n rising cannot disturb RESET_VAL.

module nand_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a & i_b);
endmodule

module not_gate (
    input  logic i_a,
    output logic o_y
);
    assign o_y = ~i_a;
endmodule

module and_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

module gate_dff #(
    parameter logic RV = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    // One storage bit, asynchronously forced to its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_q <= RV;
        else        o_q <= i_d;
    end
endmodule

module gate_updown_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_updown_counter_if.slave   bus
);
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_arm;

    logic             w_ndir, w_nload, w_en_nload;
    logic             w_en_arm, w_ld, w_nld, w_cnt_en;
    logic             w_tc, w_wrap_d;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_nq, w_s0, w_s1, w_sel, w_t;
    logic [WIDTH-1:0] w_x1, w_x2, w_x3, w_x;
    logic [WIDTH-1:0] w_m0, w_m1, w_d;

    // Arm flag: low through reset and the first edge after release
    gate_dff #(.RV(1'b0)) u_arm (.clk(clk), .rst_n(rst_n), .i_d(1'b1), .o_q(r_arm));

    not_gate u_ndir  (.i_a(bus.dir),  .o_y(w_ndir));
    not_gate u_nload (.i_a(bus.load), .o_y(w_nload));

    // Effective load / enable are held off until armed
    and_gate u_ld    (.i_a(bus.load), .i_b(r_arm), .o_y(w_ld));
    not_gate u_nld   (.i_a(w_ld),     .o_y(w_nld));
    and_gate u_enarm (.i_a(bus.en),   .i_b(r_arm), .o_y(w_en_arm));

    // Terminal count: carry out of the chain means the step would wrap
    and_gate u_tc0   (.i_a(bus.en),     .i_b(w_nload),        .o_y(w_en_nload));
    and_gate u_tc1   (.i_a(w_en_nload), .i_b(w_carry[WIDTH]), .o_y(w_tc));

`ifdef GATE_COUNTER_SATURATE_EN
    logic w_nend;
    // Kill the count step at the end value so the counter sticks there
    not_gate u_nend  (.i_a(w_carry[WIDTH]), .o_y(w_nend));
    and_gate u_sat   (.i_a(w_en_arm), .i_b(w_nend), .o_y(w_cnt_en));
    assign w_wrap_d = 1'b0;
`else
    assign w_cnt_en = w_en_arm;
    and_gate u_wrapd (.i_a(w_tc), .i_b(r_arm), .o_y(w_wrap_d));
`endif

    assign w_carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            // Carry propagate select: q when counting up, ~q when down
            not_gate  u_nq (.i_a(r_q[i]), .o_y(w_nq[i]));
            nand_gate u_s0 (.i_a(bus.dir), .i_b(r_q[i]),  .o_y(w_s0[i]));
            nand_gate u_s1 (.i_a(w_ndir),  .i_b(w_nq[i]), .o_y(w_s1[i]));
            nand_gate u_s2 (.i_a(w_s0[i]), .i_b(w_s1[i]), .o_y(w_sel[i]));
            and_gate  u_c  (.i_a(w_carry[i]), .i_b(w_sel[i]), .o_y(w_carry[i+1]));

            // Toggle this bit when the chain reaches it and counting is on
            and_gate  u_t  (.i_a(w_carry[i]), .i_b(w_cnt_en), .o_y(w_t[i]));

            // q ^ t from four NANDs
            nand_gate u_x1 (.i_a(r_q[i]),  .i_b(w_t[i]),  .o_y(w_x1[i]));
            nand_gate u_x2 (.i_a(r_q[i]),  .i_b(w_x1[i]), .o_y(w_x2[i]));
            nand_gate u_x3 (.i_a(w_t[i]),  .i_b(w_x1[i]), .o_y(w_x3[i]));
            nand_gate u_x4 (.i_a(w_x2[i]), .i_b(w_x3[i]), .o_y(w_x[i]));

            // Load mux: din when loading, else the stepped/held value
            nand_gate u_m0 (.i_a(w_ld),    .i_b(bus.din[i]), .o_y(w_m0[i]));
            nand_gate u_m1 (.i_a(w_nld),   .i_b(w_x[i]),     .o_y(w_m1[i]));
            nand_gate u_m2 (.i_a(w_m0[i]), .i_b(w_m1[i]),    .o_y(w_d[i]));

            gate_dff #(.RV(RESET_VAL[i])) u_ff (
                .clk(clk), .rst_n(rst_n), .i_d(w_d[i]), .o_q(r_q[i])
            );
        end
    endgenerate

    // Wrap is last cycle's terminal count (load/hold clear it via tc)
    gate_dff #(.RV(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .i_d(w_wrap_d), .o_q(r_wrap));

    assign bus.count = r_q;
    assign bus.tc    = w_tc;
    assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_gate_updown_counter.sv
// Self-checking bench for gate_updown_counter (WIDTH=4, RESET_VAL=0):
// directed scenarios with literal expectations plus a randomized run
// compared every cycle against an arithmetic reference model.
module tb_gate_updown_counter;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    gate_updown_counter_if #(.WIDTH(W)) bus ();

    gate_updown_counter #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   m_cnt;
    logic m_wrap;
    logic m_arm;

    // Reference model: plain integer counter with modulo/saturate rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_wrap <= 1'b0;
            m_arm  <= 1'b0;
        end else if (!m_arm) begin
            m_arm  <= 1'b1;
            m_wrap <= 1'b0;
        end else if (bus.load) begin
            m_cnt  <= int'(bus.din);
            m_wrap <= 1'b0;
        end else if (bus.en) begin
            if (bus.dir) begin
`ifdef GATE_COUNTER_SATURATE_EN
                m_cnt  <= (m_cnt == MAX) ? MAX : m_cnt + 1;
                m_wrap <= 1'b0;
`else
                m_cnt  <= (m_cnt + 1) % (MAX + 1);
                m_wrap <= (m_cnt == MAX);
`endif
            end else begin
`ifdef GATE_COUNTER_SATURATE_EN
                m_cnt  <= (m_cnt == 0) ? 0 : m_cnt - 1;
                m_wrap <= 1'b0;
`else
                m_cnt  <= (m_cnt + MAX) % (MAX + 1);
                m_wrap <= (m_cnt == 0);
`endif
            end
        end else begin
            m_wrap <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic exp_tc();
        return bus.en && !bus.load && (bus.dir ? (m_cnt == MAX) : (m_cnt == 0));
    endfunction

    task automatic compare();
        chk("model_count", 32'(bus.count), 32'(m_cnt));
        chk("model_wrap",  32'(bus.wrap),  32'(m_wrap));
        chk("model_tc",    32'(bus.tc),    32'(exp_tc()));
    endtask

    // Drive one cycle's inputs, check mid-cycle, then step past the edge
    task automatic cyc(input logic e, input logic l, input logic d, input logic [W-1:0] di);
        bus.en = e; bus.load = l; bus.dir = d; bus.din = di;
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0; bus.load = 1'b0; bus.dir = 1'b0; bus.din = '0;
        #12;
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_wrap",  32'(bus.wrap),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Async reset between edges, coinciding with a pending load
        cyc(1'b0, 1'b1, 1'b0, 4'd9);
        chk("load9", 32'(bus.count), 32'd9);
        #2;
        bus.load = 1'b1; bus.din = 4'd7;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(bus.count), 32'd0);
        chk("async_rst_wrap",  32'(bus.wrap),  32'd0);
        #4;
        bus.load = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_hold", 32'(bus.count), 32'd0);

        // Up through the top
        cyc(1'b0, 1'b1, 1'b1, 4'd14);
        chk("up_load14", 32'(bus.count), 32'd14);
        cyc(1'b1, 1'b0, 1'b1, 4'd0);
        chk("up_15", 32'(bus.count), 32'd15);
        chk("up_tc15", 32'(bus.tc), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 4'd0);
`ifdef GATE_COUNTER_SATURATE_EN
        chk("up_sat", 32'(bus.count), 32'd15);
        chk("up_sat_wrap", 32'(bus.wrap), 32'd0);
        chk("up_sat_tc", 32'(bus.tc), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 4'd0);
        chk("up_sat2", 32'(bus.count), 32'd15);
`else
        chk("up_wrap0", 32'(bus.count), 32'd0);
        chk("up_wrap_pulse", 32'(bus.wrap), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 4'd0);
        chk("up_1", 32'(bus.count), 32'd1);
        chk("up_wrap_gone", 32'(bus.wrap), 32'd0);
`endif

        // Down through zero
        cyc(1'b0, 1'b1, 1'b0, 4'd1);
        chk("dn_load1", 32'(bus.count), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        chk("dn_0", 32'(bus.count), 32'd0);
        chk("dn_tc0", 32'(bus.tc), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
`ifdef GATE_COUNTER_SATURATE_EN
        chk("dn_sat", 32'(bus.count), 32'd0);
        chk("dn_sat_wrap", 32'(bus.wrap), 32'd0);
`else
        chk("dn_15", 32'(bus.count), 32'd15);
        chk("dn_wrap_pulse", 32'(bus.wrap), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        chk("dn_14", 32'(bus.count), 32'd14);
        chk("dn_wrap_gone", 32'(bus.wrap), 32'd0);
`endif

        // Load beats enable at the terminal value
        cyc(1'b0, 1'b1, 1'b1, 4'd15);
        bus.en = 1'b1; bus.load = 1'b1; bus.dir = 1'b1; bus.din = 4'd5;
        #1;
        chk("ldpri_tc", 32'(bus.tc), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 4'd5);
        chk("ldpri_count", 32'(bus.count), 32'd5);
        chk("ldpri_wrap",  32'(bus.wrap),  32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(3) != 0), ($urandom_range(7) == 0),
                1'($urandom_range(1)), 4'($urandom_range(MAX)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
